// File: rtl/rw_flow_burst.sv
// rw_flow_burst: read/write burst flow controller.
// Accepts a command (direction + beat count) and sequences memory accesses,
// read-data capture and transmit handshakes per beat.
// Optional feature: define RW_FLOW_TIMEOUT_EN to enable a TxDone watchdog
// that aborts a TX wait after TIMEOUT cycles.
module rw_flow_burst #(
    parameter int unsigned BL_W    = 4,
    parameter int unsigned TIMEOUT = 100
) (
    input  logic            Clk,
    input  logic            ResetN,
    input  logic            Active,
    input  logic            Mode,
    input  logic            ValidCmd,
    input  logic            RW,
    input  logic [BL_W-1:0] BurstLen,
    input  logic            TxDone,
    output logic            AccessMem,
    output logic            RWMem,
    output logic            SampleData,
    output logic            TxData,
    output logic            Busy,
    output logic [BL_W-1:0] BeatCnt,
    output logic            CmdDrop,
    output logic            Error
);

    if (TIMEOUT == 0 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("rw_flow_burst: TIMEOUT must be in 1..65535");
    end

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        SAMPLE,
        TX,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            rw_q;
    logic            rw_nxt;
    logic [BL_W-1:0] len_q;
    logic [BL_W-1:0] len_nxt;
    logic [BL_W-1:0] cnt_nxt;
    logic            abort;
    logic            last_beat;
    logic            tmo;
    logic            drop_nxt;
    logic            err_nxt;

`ifdef RW_FLOW_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] wd_cnt;
    logic [15:0] wd_nxt;
`endif

    // Next-state, latched-field and pulse computation
    always_comb begin
        state_nxt = state;
        rw_nxt    = rw_q;
        len_nxt   = len_q;
        cnt_nxt   = BeatCnt;
        tmo       = 1'b0;
        abort     = (state inside {ACCESS, SAMPLE, TX}) && !(Active && Mode);
        last_beat = (BeatCnt == len_q);
        drop_nxt  = ValidCmd && (state != IDLE);
`ifdef RW_FLOW_TIMEOUT_EN
        wd_nxt    = wd_cnt;
`endif
        case (state)
            IDLE: begin
                if (ValidCmd && Active && Mode) begin
                    state_nxt = ACCESS;
                    rw_nxt    = RW;
                    len_nxt   = BurstLen;
                    cnt_nxt   = '0;
                end
            end
            ACCESS: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (rw_q) begin
                    state_nxt = SAMPLE;
                end else if (last_beat) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt   = BeatCnt + 1'b1;
                    state_nxt = ACCESS;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = TX;
`ifdef RW_FLOW_TIMEOUT_EN
                    wd_nxt    = '0;
`endif
                end
            end
            TX: begin
                // abort outranks a simultaneous TxDone
                if (abort) begin
                    state_nxt = IDLE;
                end else if (TxDone) begin
                    if (last_beat) begin
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt   = BeatCnt + 1'b1;
                        state_nxt = ACCESS;
                    end
                end else begin
`ifdef RW_FLOW_TIMEOUT_EN
                    if (wd_cnt == TO_LAST) begin
                        tmo       = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        wd_nxt = wd_cnt + 16'd1;
                    end
`endif
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        err_nxt = abort || tmo;
    end

    // State, latched fields and Moore-decoded registered outputs
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state      <= IDLE;
            rw_q       <= 1'b0;
            len_q      <= '0;
            BeatCnt    <= '0;
            AccessMem  <= 1'b0;
            RWMem      <= 1'b0;
            SampleData <= 1'b0;
            TxData     <= 1'b0;
            Busy       <= 1'b0;
            CmdDrop    <= 1'b0;
            Error      <= 1'b0;
`ifdef RW_FLOW_TIMEOUT_EN
            wd_cnt     <= '0;
`endif
        end else begin
            state      <= state_nxt;
            rw_q       <= rw_nxt;
            len_q      <= len_nxt;
            BeatCnt    <= cnt_nxt;
            AccessMem  <= (state_nxt == ACCESS);
            RWMem      <= (state_nxt == ACCESS) && rw_nxt;
            SampleData <= (state_nxt == SAMPLE);
            TxData     <= (state_nxt == TX);
            Busy       <= (state_nxt != IDLE);
            CmdDrop    <= drop_nxt;
            Error      <= err_nxt;
`ifdef RW_FLOW_TIMEOUT_EN
            wd_cnt     <= wd_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_rw_flow_burst.sv
// Bench for rw_flow_burst: each command is expanded by a transaction-level
// model into the expected per-cycle output trace, which is then replayed
// against the DUT together with the TxDone / stray ValidCmd / abort stimulus.
module tb_rw_flow_burst;

    localparam int BL_W = 4;
    localparam int TO   = 100;
`ifdef RW_FLOW_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam int K_IDLE = 0;
    localparam int K_ACC  = 1;
    localparam int K_SMP  = 2;
    localparam int K_TX   = 3;
    localparam int K_DONE = 4;

    typedef struct packed {
        logic            acc;
        logic            rwm;
        logic            smp;
        logic            txd;
        logic            busy;
        logic            drop;
        logic            err;
        logic [BL_W-1:0] cnt;
    } ov_t;

    logic            Clk = 1'b0;
    logic            ResetN;
    logic            Active;
    logic            Mode;
    logic            ValidCmd;
    logic            RW;
    logic [BL_W-1:0] BurstLen;
    logic            TxDone;
    logic            AccessMem;
    logic            RWMem;
    logic            SampleData;
    logic            TxData;
    logic            Busy;
    logic [BL_W-1:0] BeatCnt;
    logic            CmdDrop;
    logic            Error;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [BL_W-1:0] cur_cnt;
    ov_t             exp_q[$];
    bit              txd_q[$];
    bit              inj_q[$];
    int              kind_q[$];

    rw_flow_burst #(.BL_W(BL_W), .TIMEOUT(TO)) dut (
        .Clk        (Clk),
        .ResetN     (ResetN),
        .Active     (Active),
        .Mode       (Mode),
        .ValidCmd   (ValidCmd),
        .RW         (RW),
        .BurstLen   (BurstLen),
        .TxDone     (TxDone),
        .AccessMem  (AccessMem),
        .RWMem      (RWMem),
        .SampleData (SampleData),
        .TxData     (TxData),
        .Busy       (Busy),
        .BeatCnt    (BeatCnt),
        .CmdDrop    (CmdDrop),
        .Error      (Error)
    );

    always #5 Clk = ~Clk;

    function automatic bit rbit();
        return bit'($urandom & 1);
    endfunction

    function automatic ov_t obs();
        ov_t o;
        o.acc  = AccessMem;
        o.rwm  = RWMem;
        o.smp  = SampleData;
        o.txd  = TxData;
        o.busy = Busy;
        o.drop = CmdDrop;
        o.err  = Error;
        o.cnt  = BeatCnt;
        return o;
    endfunction

    task automatic check(input string tag, input int cyc, input ov_t o, input ov_t e);
        n_total++;
        assert (o === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cycle %0d: got acc/rw/smp/tx/busy/drop/err/cnt=%b/%b/%b/%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%b/%b/%b/%0d",
                   tag, cyc, o.acc, o.rwm, o.smp, o.txd, o.busy, o.drop, o.err, o.cnt,
                   e.acc, e.rwm, e.smp, e.txd, e.busy, e.drop, e.err, e.cnt);
        end
    endtask

    task automatic push(input ov_t v, input bit td, input int k);
        exp_q.push_back(v);
        txd_q.push_back(td);
        kind_q.push_back(k);
    endtask

    // abort_mode: 0 none, 1 any busy beat cycle, 2 a TX cycle via Mode=0
    task automatic run_cmd(input bit rw, input int len, input int dmin, input int dmax,
                           input bit inject, input bit noise, input int abort_mode,
                           input string tag);
        ov_t v;
        int  cand[$];
        bit  timed_out;
        int  d;
        int  a;
        int  last_busy;
        int  first_tx;
        exp_q.delete(); txd_q.delete(); inj_q.delete(); kind_q.delete();
        timed_out = 1'b0;
        a = -1;
        v = '0;
        v.cnt = cur_cnt;
        push(v, noise && rbit(), K_IDLE);
        for (int b = 0; b <= len && !timed_out; b++) begin
            v = '0; v.busy = 1'b1; v.cnt = BL_W'(b);
            v.acc = 1'b1; v.rwm = rw;
            push(v, noise && rbit(), K_ACC);
            if (rw) begin
                v.acc = 1'b0; v.rwm = 1'b0; v.smp = 1'b1;
                push(v, noise && rbit(), K_SMP);
                v.smp = 1'b0; v.txd = 1'b1;
                d = int'($urandom_range(dmax, dmin));
                if (TO_EN && d > TO) begin
                    for (int t = 0; t < TO; t++) push(v, 1'b0, K_TX);
                    timed_out = 1'b1;
                    v = '0; v.err = 1'b1; v.cnt = BL_W'(b);
                    push(v, noise && rbit(), K_IDLE);
                end else begin
                    for (int t = 1; t <= d; t++) push(v, t == d, K_TX);
                end
            end
        end
        if (timed_out) begin
            v.err = 1'b0;
            push(v, noise && rbit(), K_IDLE);
        end else begin
            v = '0; v.busy = 1'b1; v.cnt = BL_W'(len);
            push(v, noise && rbit(), K_DONE);
            v.busy = 1'b0;
            push(v, noise && rbit(), K_IDLE);
        end

        if (abort_mode != 0) begin
            for (int i = 1; i < exp_q.size(); i++)
                if (kind_q[i] == K_TX || (abort_mode == 1 && (kind_q[i] == K_ACC || kind_q[i] == K_SMP)))
                    cand.push_back(i);
            if (cand.size() > 0) begin
                a = cand[$urandom_range(cand.size() - 1, 0)];
                while (exp_q.size() > a + 1) begin
                    void'(exp_q.pop_back());
                    void'(txd_q.pop_back());
                    void'(kind_q.pop_back());
                end
                txd_q[a] = rbit();
                v = '0; v.cnt = exp_q[a].cnt; v.err = 1'b1;
                push(v, noise && rbit(), K_IDLE);
                v.err = 1'b0;
                push(v, noise && rbit(), K_IDLE);
            end
        end

        last_busy = 0;
        first_tx  = -1;
        for (int i = 1; i < exp_q.size(); i++) begin
            if (kind_q[i] != K_IDLE) last_busy = i;
            if (kind_q[i] == K_TX && first_tx < 0) first_tx = i;
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            bit inj;
            inj = inject && i >= 1 && i <= last_busy &&
                  (i == first_tx || $urandom_range(3, 0) == 0);
            inj_q.push_back(inj);
            if (inj) begin
                v = exp_q[i + 1];
                v.drop = 1'b1;
                exp_q[i + 1] = v;
            end
        end

        for (int j = 0; j < exp_q.size(); j++) begin
            @(posedge Clk); #1;
            check(tag, j, obs(), exp_q[j]);
            Active = 1'b1;
            Mode   = 1'b1;
            TxDone = txd_q[j];
            if (j == 0) begin
                ValidCmd = 1'b1; RW = rw; BurstLen = BL_W'(len);
            end else begin
                ValidCmd = inj_q[j]; RW = rbit(); BurstLen = BL_W'($urandom);
            end
            if (j == a) begin
                if (abort_mode == 2 || rbit()) Mode = 1'b0;
                else Active = 1'b0;
            end
        end
        cur_cnt = exp_q[exp_q.size() - 1].cnt;
    endtask

    initial begin
        ov_t zero;
        ov_t v;
        zero = '0;
        ResetN = 1'b0; Active = 1'b0; Mode = 1'b0; ValidCmd = 1'b0;
        RW = 1'b0; BurstLen = '0; TxDone = 1'b0;
        cur_cnt = '0;

        repeat (2) @(posedge Clk);
        #1 check("reset_hold", 0, obs(), zero);
        @(negedge Clk); ResetN = 1'b1;

        // commands without both Active and Mode high are not accepted
        for (int j = 0; j < 6; j++) begin
            @(posedge Clk); #1;
            check("idle_ignore", j, obs(), zero);
            ValidCmd = 1'b1;
            Active   = (j % 3) == 1;
            Mode     = (j % 3) == 2;
            TxDone   = rbit();
        end
        @(posedge Clk); #1;
        check("idle_ignore", 6, obs(), zero);
        ValidCmd = 1'b0; Active = 1'b1; Mode = 1'b1; TxDone = 1'b0;

        run_cmd(1'b1, 0, 16, 16, 1'b0, 1'b0, 0, "single_read");
        run_cmd(1'b1, 3, 4, 4, 1'b0, 1'b0, 0, "read_burst");
        run_cmd(1'b0, 2, 1, 1, 1'b0, 1'b0, 0, "write_burst");
        run_cmd(1'b1, 1, 12, 12, 1'b1, 1'b0, 0, "drop_in_tx");
        run_cmd(1'b1, 2, 12, 12, 1'b0, 1'b0, 2, "abort_tx");
        run_cmd(1'b1, 0, 301, 301, 1'b0, 1'b0, 0, "tx_watchdog");
        run_cmd(1'b1, 15, 1, 3, 1'b1, 1'b1, 0, "read_max");
        run_cmd(1'b0, 15, 1, 1, 1'b1, 1'b1, 0, "write_max");
        for (int k = 0; k < 25; k++)
            run_cmd(rbit(), int'($urandom_range(15, 0)), 1, 6, 1'b1, 1'b1,
                    ($urandom_range(3, 0) == 0) ? 1 : 0, "random");

        // asynchronous reset in the middle of a TX wait
        @(posedge Clk); #1;
        ValidCmd = 1'b1; RW = 1'b1; BurstLen = 4'd2; TxDone = 1'b0;
        Active = 1'b1; Mode = 1'b1;
        @(posedge Clk); #1;
        ValidCmd = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #3;
        v = '0; v.busy = 1'b1; v.txd = 1'b1;
        check("rst_pre_tx", 0, obs(), v);
        ResetN = 1'b0;
        #1 check("rst_async", 0, obs(), zero);
        @(negedge Clk); ResetN = 1'b1;
        cur_cnt = '0;
        for (int j = 0; j < 8; j++) begin
            @(posedge Clk); #1;
            check("rst_quiet", j, obs(), zero);
            TxDone = rbit();
        end
        TxDone = 1'b0;
        run_cmd(1'b1, 1, 2, 5, 1'b0, 1'b0, 0, "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rw_flow_burst.md
RW_FLOW_BURST -- requirements
Module: rw_flow_burst

Interface
REQ-001 Parameter BL_W, default 4, SHALL set the width of the burst-length field.
REQ-002 Parameter TIMEOUT, default 100, SHALL set the TxDone watchdog limit in clock cycles (range 1..65535).
REQ-003 Clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-004 ResetN  input  1  reset, asynchronous, active-low.
REQ-005 Active  input  1  controller enable; commands are accepted only while high.
REQ-006 Mode  input  1  1 = memory-transfer mode; commands are ignored while low.
REQ-007 ValidCmd  input  1  single-cycle command strobe.
REQ-008 RW  input  1  command direction: 1 = read, 0 = write; sampled with ValidCmd.
REQ-009 BurstLen  input  BL_W  beat count minus one; sampled with ValidCmd.
REQ-010 TxDone  input  1  transmitter completion strobe.
REQ-011 AccessMem  output  1  memory access strobe, one cycle per beat.
REQ-012 RWMem  output  1  latched direction driven to memory; valid while AccessMem is high.
REQ-013 SampleData  output  1  capture strobe for read data, one cycle per read beat.
REQ-014 TxData  output  1  transmit request, held high until TxDone or abort.
REQ-015 Busy  output  1  high in every state except IDLE.
REQ-016 BeatCnt  output  BL_W  index of the current beat, counting from 0.
REQ-017 CmdDrop  output  1  one-cycle pulse when ValidCmd arrives while Busy.
REQ-018 Error  output  1  one-cycle pulse on abort or timeout.

Function
REQ-019 Every output SHALL be registered and SHALL be a Moore decode of the state, except CmdDrop and Error, which are registered pulses.
REQ-020 The state machine SHALL have the states IDLE, ACCESS, SAMPLE, TX and DONE.
REQ-021 In IDLE, when ValidCmd&Active&Mode is high, the block SHALL latch RW and BurstLen, clear BeatCnt and enter ACCESS; AccessMem SHALL be high in the cycle following the ValidCmd edge.
REQ-022 In ACCESS, AccessMem SHALL be 1 and RWMem SHALL be the latched RW, for one cycle; next state SHALL be SAMPLE for a read and DONE-check for a write.
REQ-023 In SAMPLE, SampleData SHALL be 1 for one cycle; next state SHALL be TX.
REQ-024 In TX, TxData SHALL be 1; on TxDone the beat SHALL complete.
REQ-025 On beat completion, if BeatCnt equals the latched BurstLen the block SHALL enter DONE; otherwise it SHALL increment BeatCnt and return to ACCESS.
REQ-026 A write beat SHALL complete in ACCESS without SAMPLE or TX, so a write burst of N beats SHALL take N consecutive AccessMem cycles.
REQ-027 DONE SHALL last one cycle, with Busy high, and then return to IDLE; a new command SHALL be accepted at the earliest in the IDLE cycle that follows.
REQ-028 A read burst of BurstLen=0 SHALL take exactly one beat; BurstLen at its maximum value, (2^BL_W)-1, SHALL give 2^BL_W beats, and BeatCnt SHALL NOT wrap during the burst.
REQ-029 ValidCmd arriving in any non-IDLE state SHALL be ignored, leaving the latched fields unchanged, and SHALL raise CmdDrop in the next cycle.
REQ-030 Active or Mode low in any state other than IDLE or DONE SHALL abort: next state IDLE, all strobes low, and Error pulsed.
REQ-031 TxDone outside the TX state SHALL be ignored.
REQ-032 TxDone and an abort in the same cycle SHALL resolve as an abort.

Reset
REQ-033 ResetN low SHALL immediately force IDLE with every output 0, BeatCnt 0, the latched fields 0 and the watchdog counter 0, independent of Clk.
REQ-034 Reset asserted mid-burst SHALL discard the burst; after release no output SHALL assert until a new valid command arrives.

Configuration
REQ-035 With macro RW_FLOW_TIMEOUT_EN defined, a counter SHALL run while in TX, clearing on TX entry.
REQ-036 With RW_FLOW_TIMEOUT_EN defined, if TIMEOUT cycles elapse in TX without TxDone, the block SHALL pulse Error and return to IDLE.
REQ-037 Without RW_FLOW_TIMEOUT_EN, TX SHALL wait indefinitely, the counter SHALL be absent, and Error SHALL pulse only on abort.

Verification
REQ-038 The bench SHALL cover a single read: release ResetN, then Active=Mode=1, RW=1, BurstLen=0, ValidCmd pulse, TxDone after 16 cycles -> one AccessMem pulse, RWMem=1, one SampleData pulse, TxData high for 16 cycles, Busy low 2 cycles after TxDone.
REQ-039 The bench SHALL cover a read burst: BurstLen=3 with TxDone 4 cycles after each TxData rise -> 4 access/sample/tx sequences, BeatCnt stepping 0,1,2,3, and Error=0.
REQ-040 The bench SHALL cover a write burst: RW=0, BurstLen=2 -> AccessMem high for 3 consecutive cycles with RWMem=0, no SampleData, no TxData.
REQ-041 The bench SHALL cover drop and abort: a ValidCmd during TX -> CmdDrop pulse and burst unaffected; then Mode=0 during TX -> Error pulse, TxData low, Busy low in the next cycle.
REQ-042 The bench SHALL cover the timeout with RW_FLOW_TIMEOUT_EN defined and TIMEOUT=100: a read with no TxDone -> Error pulse after 100 TX cycles and return to IDLE; without the macro, TxData stays high for 300 cycles.
REQ-043 The bench SHALL cover async reset: ResetN low mid-TX, between clock edges -> all outputs 0 immediately; no output activity until the next ValidCmd.
